// File: rtl/cdb_pkg.sv
// Shared CDB definitions: unit indices, default widths and the broadcast bus type.
// CDB consumers reuse cdb_bus_t to snoop the registered broadcast.
package cdb_pkg;

  localparam int NUM_CDB_UNITS = 4;
  localparam int CDB_TAG_W     = 6;
  localparam int CDB_DATA_W    = 32;

  typedef enum logic [1:0] {
    CDB_ALU = 2'd0,
    CDB_MUL = 2'd1,
    CDB_DIV = 2'd2,
    CDB_AGU = 2'd3
  } cdb_unit_e;

  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_bus_t;

endpackage

// File: rtl/cdb_rr_picker.sv
// Combinational CDB winner picker: one-hot grant plus winner index from a 4-bit request.
// CDB_ARB_RR_EN selects round-robin from ptr_i; otherwise fixed priority DIV > MUL > AGU > ALU.
module cdb_rr_picker
  import cdb_pkg::*;
(
  input  logic [NUM_CDB_UNITS-1:0] req_i,
  input  logic [1:0]               ptr_i,
  output logic [NUM_CDB_UNITS-1:0] gnt_o,
  output logic [1:0]               winner_o
);

`ifdef CDB_ARB_RR_EN
  always_comb begin : rr_search
    logic       found;
    logic [1:0] idx;
    gnt_o    = '0;
    winner_o = 2'd0;
    found    = 1'b0;
    idx      = 2'd0;
    // Walk ptr, ptr+1, ... and let the 2-bit index wrap naturally.
    for (int i = 0; i < NUM_CDB_UNITS; i++) begin
      idx = ptr_i + 2'(i);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        winner_o   = idx;
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;

  always_comb begin
    gnt_o    = '0;
    winner_o = 2'd0;
    if (req_i[CDB_DIV]) begin
      gnt_o[CDB_DIV] = 1'b1;
      winner_o       = CDB_DIV;
    end else if (req_i[CDB_MUL]) begin
      gnt_o[CDB_MUL] = 1'b1;
      winner_o       = CDB_MUL;
    end else if (req_i[CDB_AGU]) begin
      gnt_o[CDB_AGU] = 1'b1;
      winner_o       = CDB_AGU;
    end else if (req_i[CDB_ALU]) begin
      gnt_o[CDB_ALU] = 1'b1;
      winner_o       = CDB_ALU;
    end
  end
`endif

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: grants one of ALU/MUL/DIV/AGU per cycle and registers the winner.
// CDB_ARB_RR_EN enables round-robin with a priority pointer; default build is fixed priority.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int DATA_W = CDB_DATA_W,
  parameter int TAG_W  = CDB_TAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_req,
  input  logic              mul_req,
  input  logic              div_req,
  input  logic              agu_req,
  input  logic [TAG_W-1:0]  alu_tag,
  input  logic [TAG_W-1:0]  mul_tag,
  input  logic [TAG_W-1:0]  div_tag,
  input  logic [TAG_W-1:0]  agu_tag,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [DATA_W-1:0] mul_data,
  input  logic [DATA_W-1:0] div_data,
  input  logic [DATA_W-1:0] agu_data,
  output logic              alu_gnt,
  output logic              mul_gnt,
  output logic              div_gnt,
  output logic              agu_gnt,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data
);

  // Handshake: a unit with req high sees gnt in the same cycle and its result
  // is consumed at the next posedge; gnt is never raised without req.
  logic [NUM_CDB_UNITS-1:0] req_vec;
  logic [NUM_CDB_UNITS-1:0] pick_gnt;
  logic [NUM_CDB_UNITS-1:0] gnt_vec;
  logic [1:0]               winner;
  logic [1:0]               ptr;
  logic                     handshake;

  assign req_vec = {agu_req, div_req, mul_req, alu_req};

  cdb_rr_picker u_picker (
    .req_i    (req_vec),
    .ptr_i    (ptr),
    .gnt_o    (pick_gnt),
    .winner_o (winner)
  );

  assign gnt_vec   = rst ? '0 : pick_gnt;
  assign alu_gnt   = gnt_vec[CDB_ALU];
  assign mul_gnt   = gnt_vec[CDB_MUL];
  assign div_gnt   = gnt_vec[CDB_DIV];
  assign agu_gnt   = gnt_vec[CDB_AGU];
  assign handshake = |gnt_vec;

`ifdef CDB_ARB_RR_EN
  logic [1:0] ptr_q;
  logic [1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (handshake) ptr_d = winner + 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 2'd0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = 2'd0;
`endif

  logic [TAG_W-1:0]  sel_tag;
  logic [DATA_W-1:0] sel_data;

  always_comb begin
    sel_tag  = alu_tag;
    sel_data = alu_data;
    case (cdb_unit_e'(winner))
      CDB_ALU: begin sel_tag = alu_tag; sel_data = alu_data; end
      CDB_MUL: begin sel_tag = mul_tag; sel_data = mul_data; end
      CDB_DIV: begin sel_tag = div_tag; sel_data = div_data; end
      CDB_AGU: begin sel_tag = agu_tag; sel_data = agu_data; end
      default: begin sel_tag = alu_tag; sel_data = alu_data; end
    endcase
  end

  logic              valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Tag and data hold across idle cycles; only valid drops.
  always_comb begin
    valid_d = handshake;
    tag_d   = tag_q;
    data_d  = data_q;
    if (handshake) begin
      tag_d  = sel_tag;
      data_d = sel_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign cdb_valid = valid_q;
  assign cdb_tag   = tag_q;
  assign cdb_data  = data_q;

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbitrates the single Common Data Bus between the four execution units (ALU, MUL, DIV, AGU) of the Tomasulo back end. Each unit holds a finished result (tag + data) until it receives a grant. The arbiter grants at most one unit per cycle and broadcasts the winner's tag and data on a registered CDB. Reservation stations and the register-status table snoop that CDB. It sits between the execution-unit outputs and every CDB consumer, downstream of the dispatch stage.

## Interface
Parameters:
- DATA_W, 32, width of the result data
- TAG_W, 6, width of the producer (ROB/RS) tag

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- alu_req / mul_req / div_req / agu_req  in  1 each  unit holds a valid result
- alu_tag / mul_tag / div_tag / agu_tag  in  TAG_W each  producer tag of the held result
- alu_data / mul_data / div_data / agu_data  in  DATA_W each  result value
- alu_gnt / mul_gnt / div_gnt / agu_gnt  out  1 each  combinational grant; result is consumed at the next posedge
- cdb_valid  out  1  registered broadcast valid
- cdb_tag  out  TAG_W  registered broadcast tag
- cdb_data  out  DATA_W  registered broadcast data

## Operation
- Unit index mapping: 0 = ALU, 1 = MUL, 2 = DIV, 3 = AGU.
- Grant vector:
  - Combinational from the req vector and the priority pointer `ptr` (2 bits).
  - At most one grant is high per cycle.
  - No grant is issued when no req is high.
- Round-robin (CDB_ARB_RR_EN defined):
  - Search starts at index `ptr` and proceeds `ptr`, `ptr`+1, … modulo 4.
  - The first requesting index wins.
  - On a handshake (req & gnt) at a posedge, `ptr` <= winner + 1 (mod 4; wraps 3 -> 0).
  - With no handshake, `ptr` holds.
- Requester protocol:
  - Once req is high, req, tag and data stay stable until the cycle in which gnt is high.
  - req drops in the cycle after the handshake unless a new result is ready.
  - The arbiter does not check for protocol violations.
- CDB register:
  - On a handshake, cdb_valid <= 1, and cdb_tag / cdb_data <= the winner's tag and data.
  - With no handshake, cdb_valid <= 0; cdb_tag and cdb_data hold their last values.
- Winner selection is a pure mux of the granted unit's inputs. No arithmetic is performed on data.
- Reset values: cdb_valid = 0, cdb_tag = 0, cdb_data = 0, `ptr` = 0.
- Grants are low while rst is asserted.
- Reset asserted mid-operation clears state immediately. Pending reqs are re-arbitrated from `ptr` = 0 after release.

## Timing
- Latency is 1 cycle: a req granted in cycle N appears on the CDB (cdb_valid = 1) in cycle N+1.
- Throughput is one result per cycle. Back-to-back grants are allowed, including to the same unit when it is the only requester.
- Fairness (RR build): a continuously requesting unit is granted within 4 cycles.
- Simultaneous requests: exactly one winner per cycle; the losers keep req high and are served in later cycles.
- The grant path is purely combinational: req -> gnt in the same cycle, with no register between them.

## Configuration
- CDB_ARB_RR_EN defined: round-robin with the `ptr` register, as described under Operation.
- CDB_ARB_RR_EN undefined:
  - Fixed priority DIV > MUL > AGU > ALU.
  - The `ptr` register is not implemented.
  - A unit with continuous requests can starve lower-priority units.

## Structure
- Shared package `cdb_pkg`:
  - typedef enum logic [1:0] cdb_unit_e {CDB_ALU, CDB_MUL, CDB_DIV, CDB_AGU}
  - localparam NUM_CDB_UNITS = 4
  - packed struct cdb_bus_t {valid, tag, data}, which the CDB consumers reuse
- Sub-module `cdb_rr_picker`:
  - Inputs: 4-bit req, 2-bit ptr.
  - Outputs: one-hot 4-bit gnt, 2-bit winner index.
  - Combinational.
  - In the fixed-priority build it ignores ptr.
- Top level holds the `ptr` register, the output mux and the CDB register.

## Test plan
- Reset: rst high with all reqs high -> all gnt = 0, cdb_valid = 0, cdb_tag = 0, cdb_data = 0. After release -> alu_gnt = 1 (RR build, ptr = 0).
- Single requester: mul_req = 1, tag 0x05, data 0xDEADBEEF in cycle N -> mul_gnt = 1 in cycle N. In cycle N+1: cdb_valid = 1, cdb_tag = 0x05, cdb_data = 0xDEADBEEF.
- All four requesting continuously (RR build) -> grant order ALU, MUL, DIV, AGU, ALU…. One grant per cycle; cdb_valid stays 1 throughout.
- Wrap-around: ptr = 3 with reqs from AGU and ALU -> AGU granted first. Next cycle ALU is granted, and ptr becomes 1.
- Fixed-priority build, all four requesting -> div_gnt = 1 every cycle while div_req stays high. alu_gnt stays 0.
- Async reset mid-stream: rst pulsed between clock edges while cdb_valid = 1 -> cdb_valid = 0 immediately, before the next edge. ptr = 0, so ALU is granted first after release.
